// File: rtl/keypad_row_scanner.sv
// keypad_row_scanner: one-hot keypad row scan with dwell timing and key decode
module keypad_row_scanner #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enRow,
  input  logic       press,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       keyValid
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] row_q, row_d, key_q, key_d;
  logic key_valid_q, key_valid_d;
  logic wrap, col_ok;
  logic [1:0] ridx, cidx;
  assign ridx = {row_q[3] | row_q[2], row_q[3] | row_q[1]};
  assign cidx = {col[3] | col[2], col[3] | col[1]};
  assign col_ok = (col != 4'd0) && ((col & (col - 4'd1)) == 4'd0);
  assign wrap = cnt_q == CW'(SCAN_DIV - 1);
  // dwell count and row rotation; decode the pre-advance row on a clean single-column press
  always_comb begin
    cnt_d = enRow ? (wrap ? '0 : cnt_q + CW'(1)) : '0;
    row_d = (enRow && wrap) ? {row_q[2:0], row_q[3]} : row_q;
    key_valid_d = press && col_ok;
    key_d = key_valid_d ? KEYMAP[{ridx, cidx, 2'b00} +: 4] : key_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      row_q <= 4'b0001;
      key_q <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
      key_q <= key_d;
      key_valid_q <= key_valid_d;
    end
  end
  assign row = row_q;
  assign key = key_q;
  assign keyValid = key_valid_q;
endmodule
